// File: rtl/icu_wide.sv
// Lane-parallel MC14500B-style control unit: valid/ready instruction port,
// backpressured store port and an enable-mask context stack for JMP/RTN.
module icu_wide #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4,
    localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       instr,
    input  logic [WIDTH-1:0] data_in,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] wr_mask,
    output logic [WIDTH-1:0] rr_out,
    output logic             jmp_o,
    output logic             rtn_o,
    output logic             flag_o,
    output logic             flag_f,
    output logic             skip_o,
    output logic [DW-1:0]    depth_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    logic [WIDTH-1:0] rr_q, rr_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] oen_q, oen_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [WIDTH-1:0] wr_mask_q, wr_mask_d;
    logic             wr_valid_q, wr_valid_d;
    logic             skip_q, skip_d;
    logic             jmp_q, jmp_d;
    logic             rtn_q, rtn_d;
    logic             flag_o_q, flag_o_d;
    logic             flag_f_q, flag_f_d;
    logic             skip_p_q, skip_p_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [STACK_DEPTH-1:0][2*WIDTH-1:0] stack_q, stack_d;

    logic                 accept;
    logic [WIDTH-1:0]     dm;
    logic [2*WIDTH-1:0]   top_ctx;

    assign in_ready = !wr_valid_q || wr_ready;
    assign accept   = in_valid && in_ready;
    assign dm       = data_in & ien_q;

    // Entry that the next RTN would restore (slot depth-1).
    always_comb begin
        top_ctx = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DW'(i + 1) == depth_q) top_ctx = stack_q[i];
        end
    end

    always_comb begin
        rr_d       = rr_q;
        ien_d      = ien_q;
        oen_d      = oen_q;
        wr_data_d  = wr_data_q;
        wr_mask_d  = wr_mask_q;
        wr_valid_d = wr_valid_q;
        skip_d     = skip_q;
        depth_d    = depth_q;
        stack_d    = stack_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        jmp_d      = 1'b0;
        rtn_d      = 1'b0;
        flag_o_d   = 1'b0;
        flag_f_d   = 1'b0;
        skip_p_d   = 1'b0;

        // A pending store retires on wr_ready even if a new STO refills it below.
        if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

        if (accept) begin
            if (skip_q) begin
                skip_d   = 1'b0;
                skip_p_d = 1'b1;
            end else begin
                case (instr)
                    OP_NOPO: flag_o_d = 1'b1;
                    OP_LD:   rr_d = dm;
                    OP_LDC:  rr_d = ~dm;
                    OP_AND:  rr_d = rr_q & dm;
                    OP_ANDC: rr_d = rr_q & ~dm;
                    OP_OR:   rr_d = rr_q | dm;
                    OP_ORC:  rr_d = rr_q | ~dm;
                    OP_XNOR: rr_d = rr_q ~^ dm;
                    OP_STO, OP_STOC: begin
                        if (oen_q != '0) begin
                            wr_valid_d = 1'b1;
                            wr_data_d  = (instr == OP_STOC) ? ~rr_q : rr_q;
                            wr_mask_d  = oen_q;
                        end
                    end
                    OP_IEN:  ien_d = data_in;
                    OP_OEN:  oen_d = dm;
                    OP_JMP: begin
                        jmp_d = 1'b1;
                        if (depth_q < DW'(STACK_DEPTH)) begin
                            for (int i = 0; i < STACK_DEPTH; i++) begin
                                if (DW'(i) == depth_q) stack_d[i] = {ien_q, oen_q};
                            end
                            depth_d = depth_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    OP_RTN: begin
                        rtn_d  = 1'b1;
                        skip_d = 1'b1;
                        if (depth_q != '0) begin
                            ien_d   = top_ctx[2*WIDTH-1:WIDTH];
                            oen_d   = top_ctx[WIDTH-1:0];
                            depth_d = depth_q - 1'b1;
                        end else begin
                            unf_d = 1'b1;
                        end
                    end
                    OP_SKZ:  if (rr_q == '0) skip_d = 1'b1;
                    OP_NOPF: flag_f_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            ien_q      <= '0;
            oen_q      <= '0;
            wr_data_q  <= '0;
            wr_mask_q  <= '0;
            wr_valid_q <= 1'b0;
            skip_q     <= 1'b0;
            depth_q    <= '0;
            stack_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            jmp_q      <= 1'b0;
            rtn_q      <= 1'b0;
            flag_o_q   <= 1'b0;
            flag_f_q   <= 1'b0;
            skip_p_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            ien_q      <= ien_d;
            oen_q      <= oen_d;
            wr_data_q  <= wr_data_d;
            wr_mask_q  <= wr_mask_d;
            wr_valid_q <= wr_valid_d;
            skip_q     <= skip_d;
            depth_q    <= depth_d;
            stack_q    <= stack_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            jmp_q      <= jmp_d;
            rtn_q      <= rtn_d;
            flag_o_q   <= flag_o_d;
            flag_f_q   <= flag_f_d;
            skip_p_q   <= skip_p_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign wr_mask  = wr_mask_q;
    assign rr_out   = rr_q;
    assign jmp_o    = jmp_q;
    assign rtn_o    = rtn_q;
    assign flag_o   = flag_o_q;
    assign flag_f   = flag_f_q;
    assign skip_o   = skip_p_q;
    assign depth_o  = depth_q;
    assign ovf_o    = ovf_q;
    assign unf_o    = unf_q;

endmodule

// File: tb/tb_icu_wide.sv
// Scoreboard bench for icu_wide: WIDTH=8, STACK_DEPTH=2.
module tb_icu_wide;

    localparam int W  = 8;
    localparam int SD = 2;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    instr;
    logic [W-1:0]  data_in;
    logic          wr_valid;
    logic          wr_ready;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  wr_mask;
    logic [W-1:0]  rr_out;
    logic          jmp_o, rtn_o, flag_o, flag_f, skip_o;
    logic [DW-1:0] depth_o;
    logic          ovf_o, unf_o;

    icu_wide #(.WIDTH(W), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .data_in(data_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mask(wr_mask), .rr_out(rr_out), .jmp_o(jmp_o),
        .rtn_o(rtn_o), .flag_o(flag_o), .flag_f(flag_f), .skip_o(skip_o),
        .depth_o(depth_o), .ovf_o(ovf_o), .unf_o(unf_o)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] NOPO = 4'h0, LD = 4'h1, AND_ = 4'h3, OR_ = 4'h5, XNOR_ = 4'h7,
                           STO = 4'h8, STOC = 4'h9, IEN = 4'hA, OEN = 4'hB, JMP = 4'hC,
                           RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF;

    typedef struct {
        string        tag;
        logic [W-1:0] rr;
        logic [4:0]   pul;   // {jmp, rtn, flag_o, flag_f, skip}
        int           dep;
        logic         ovf, unf, wv;
        logic [W-1:0] wd, wm;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [W-1:0]   m_rr, m_ien, m_oen, m_wd, m_wm;
    logic           m_skip, m_ovf, m_unf, m_wv;
    int             m_depth;
    logic [2*W-1:0] m_stk [SD];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = '0; m_ien = '0; m_oen = '0; m_wd = '0; m_wm = '0;
        m_skip = 0; m_ovf = 0; m_unf = 0; m_wv = 0; m_depth = 0;
        for (int i = 0; i < SD; i++) m_stk[i] = '0;
    endtask

    task automatic model_push(input string tag, input logic [3:0] op, input logic [W-1:0] d);
        exp_t e;
        logic [W-1:0] dmv;
        dmv = d & m_ien;
        e.pul = '0;
        m_wv = 1'b0;
        if (m_skip) begin
            m_skip = 1'b0;
            e.pul[0] = 1'b1;
        end else begin
            case (op)
                4'h0: e.pul[2] = 1'b1;
                4'h1: m_rr = dmv;
                4'h2: m_rr = ~dmv;
                4'h3: m_rr = m_rr & dmv;
                4'h4: m_rr = m_rr & ~dmv;
                4'h5: m_rr = m_rr | dmv;
                4'h6: m_rr = m_rr | ~dmv;
                4'h7: m_rr = ~(m_rr ^ dmv);
                4'h8, 4'h9: if (m_oen != 0) begin
                    m_wv = 1'b1;
                    m_wd = (op == 4'h9) ? ~m_rr : m_rr;
                    m_wm = m_oen;
                end
                4'hA: m_ien = d;
                4'hB: m_oen = dmv;
                4'hC: begin
                    e.pul[4] = 1'b1;
                    if (m_depth < SD) begin
                        m_stk[m_depth] = {m_ien, m_oen};
                        m_depth++;
                    end else m_ovf = 1'b1;
                end
                4'hD: begin
                    e.pul[3] = 1'b1;
                    m_skip = 1'b1;
                    if (m_depth > 0) begin
                        m_depth--;
                        {m_ien, m_oen} = m_stk[m_depth];
                    end else m_unf = 1'b1;
                end
                4'hE: if (m_rr == 0) m_skip = 1'b1;
                4'hF: e.pul[1] = 1'b1;
            endcase
        end
        e.tag = tag; e.rr = m_rr; e.dep = m_depth; e.ovf = m_ovf; e.unf = m_unf;
        e.wv = m_wv; e.wd = m_wd; e.wm = m_wm;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".rr"},    rr_out, e.rr);
        check({e.tag, ".pulse"}, {jmp_o, rtn_o, flag_o, flag_f, skip_o}, e.pul);
        check({e.tag, ".depth"}, depth_o, e.dep);
        check({e.tag, ".ovf"},   ovf_o, e.ovf);
        check({e.tag, ".unf"},   unf_o, e.unf);
        check({e.tag, ".wv"},    wr_valid, e.wv);
        check({e.tag, ".wd"},    wr_data, e.wd);
        check({e.tag, ".wm"},    wr_mask, e.wm);
    endtask

    task automatic exec(input logic [3:0] op, input logic [W-1:0] d, input logic rdy, input string tag);
        int cnt;
        instr = op; data_in = d; wr_ready = rdy; in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) check({tag, ".accept_timeout"}, 0, 1);
        model_push(tag, op, d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        compare_pop();
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; instr = '0; data_in = '0; wr_ready = 0;
        model_reset();
        #12;
        check("rst.rr", rr_out, 0);
        check("rst.wv", wr_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.depth", depth_o, 0);
        check("rst.flags", {ovf_o, unf_o, jmp_o, rtn_o, flag_o, flag_f, skip_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Logic and masking
        exec(IEN, 8'hFF, 1, "ien_ff");
        exec(LD, 8'hA5, 1, "ld_a5");     check("plan.ld", rr_out, 8'hA5);
        exec(AND_, 8'h0F, 1, "and_0f");  check("plan.and", rr_out, 8'h05);
        exec(OR_, 8'h30, 1, "or_30");    check("plan.or", rr_out, 8'h35);
        exec(XNOR_, 8'hFF, 1, "xnor_ff"); check("plan.xnor", rr_out, 8'h35);
        exec(IEN, 8'h0F, 1, "ien_0f");
        exec(LD, 8'hFF, 1, "ld_masked"); check("plan.masked", rr_out, 8'h0F);
        exec(NOPO, 0, 1, "nopo1");
        exec(NOPO, 0, 1, "nopo2");
        exec(NOPF, 0, 1, "nopf");
        @(posedge clk); #1;
        check("idle.pulses", {jmp_o, rtn_o, flag_o, flag_f, skip_o}, 0);

        // Store backpressure
        exec(IEN, 8'hFF, 1, "ien_ff2");
        exec(OEN, 8'h3C, 1, "oen_3c");
        exec(LD, 8'h5A, 1, "ld_5a");
        exec(STOC, 0, 0, "stoc");
        instr = NOPO; data_in = '0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp.wv", wr_valid, 1);
            check("bp.wd", wr_data, 8'hA5);
            check("bp.wm", wr_mask, 8'h3C);
            check("bp.in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        check("bp.no_accept", flag_o, 0);
        exec(NOPO, 0, 1, "bp_drain");
        exec(OEN, 8'h00, 1, "oen_00");
        exec(STO, 0, 1, "sto_drop");     check("plan.sto_drop", wr_valid, 0);
        exec(OEN, 8'hFF, 1, "oen_ff");
        exec(STO, 0, 0, "sto_a");
        exec(STOC, 0, 1, "stoc_b2b");    check("plan.b2b_wd", wr_data, 8'hA5);
        exec(NOPO, 0, 1, "b2b_drain");

        // Skip
        exec(LD, 8'h00, 1, "ld_00");
        exec(SKZ, 0, 1, "skz_z");
        repeat (2) @(posedge clk);
        #1;
        check("skz.idle_skip_o", skip_o, 0);
        exec(LD, 8'hFF, 1, "ld_skipped"); check("plan.skipped", rr_out, 8'h00);
        exec(LD, 8'h01, 1, "ld_01");
        exec(SKZ, 0, 1, "skz_nz");
        exec(LD, 8'hFF, 1, "ld_taken");  check("plan.taken", rr_out, 8'hFF);
        exec(JMP, 0, 1, "jmp0");
        exec(RTN, 0, 1, "rtn0");
        exec(NOPO, 0, 1, "nopo_skipped"); check("plan.rtn_skip", flag_o, 0);

        // Context stack
        exec(IEN, 8'h11, 1, "ien_11");
        exec(JMP, 0, 1, "jmp1");
        exec(IEN, 8'h22, 1, "ien_22");
        exec(JMP, 0, 1, "jmp2");
        exec(IEN, 8'h33, 1, "ien_33");
        exec(JMP, 0, 1, "jmp_ovf");      check("plan.ovf", {ovf_o, depth_o}, {1'b1, DW'(2)});
        exec(RTN, 0, 1, "rtn1");
        exec(NOPO, 0, 1, "skip1");
        exec(LD, 8'hFF, 1, "ld_ien22");  check("plan.ien22", rr_out, 8'h22);
        exec(RTN, 0, 1, "rtn2");
        exec(NOPO, 0, 1, "skip2");
        exec(LD, 8'hFF, 1, "ld_ien11");  check("plan.ien11", rr_out, 8'h11);
        exec(RTN, 0, 1, "rtn_unf");      check("plan.unf", {unf_o, depth_o}, {1'b1, DW'(0)});
        exec(NOPO, 0, 1, "skip3");

        // Asynchronous reset during a pending store
        exec(JMP, 0, 1, "jmp_r");
        exec(OEN, 8'hFF, 1, "oen_r");
        exec(LD, 8'hFF, 1, "ld_r");
        exec(STO, 0, 0, "sto_r");
        check("pre_rst.state", {wr_valid, depth_o}, {1'b1, DW'(1)});
        #2;
        rst = 1'b1;
        #1;
        check("arst.rr", rr_out, 0);
        check("arst.wr", {wr_valid, wr_data, wr_mask}, 0);
        check("arst.depth", depth_o, 0);
        check("arst.flags", {ovf_o, unf_o, jmp_o, rtn_o, flag_o, flag_f, skip_o}, 0);
        check("arst.in_ready", in_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", in_ready, 1);
        exec(IEN, 8'hFF, 1, "ien_post");
        exec(LD, 8'h3C, 1, "ld_post");

        if (sb.size() != 0) check("sb.leftover", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
